// File: rtl/reg_fill_ctrl_pkg.sv
// reg_fill_ctrl_pkg: shared register-set constants, fill FSM states and one-hot decode.
package reg_fill_ctrl_pkg;
  localparam int NUM_REGS = 32;
  localparam int IDX_W = 5;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;
  function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction
endpackage

// File: rtl/reg_fill_ctrl_onehot_dec.sv
// onehot_dec: register index to one-hot select, shared with the read-side mux.
module onehot_dec
  import reg_fill_ctrl_pkg::*;
(
  input  logic [IDX_W-1:0]    i_idx,
  output logic [NUM_REGS-1:0] o_onehot
);
  assign o_onehot = onehot(i_idx);
endmodule

// File: rtl/reg_fill_ctrl.sv
// reg_fill_ctrl: write-side controller filling consecutive registers from memory
// and forwarding single CPU writes while idle.
module reg_fill_ctrl
  import reg_fill_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                fill_start,
  input  logic [IDX_W-1:0]    fill_base,
  input  logic [IDX_W:0]      fill_len,
  input  logic [ADDR_W-1:0]   fill_addr,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                cpu_we,
  input  logic [IDX_W-1:0]    cpu_idx,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_stall,
  output logic                regWrite,
  output logic [NUM_REGS-1:0] decOut,
  output logic [DATA_W-1:0]   writeData,
  output logic                busy,
  output logic                fill_done
);
  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W:0]       r_len;
  logic [IDX_W:0]       r_count;
  logic [ADDR_W-1:0]    r_base;
  logic [IDX_W:0]       w_len;
  logic [IDX_W:0]       w_cnt_nx;
  logic [IDX_W-1:0]     w_dec_idx;
  logic [NUM_REGS-1:0]  w_dec;
  logic                 w_cpu_go;
  assign cpu_stall = busy | fill_start;
  assign w_cpu_go = cpu_we & ~cpu_stall;
  assign w_len = (fill_len > (IDX_W+1)'(NUM_REGS)) ? (IDX_W+1)'(NUM_REGS) : fill_len;
  assign w_cnt_nx = r_count + 1'b1;
  // The CPU index only matters in IDLE; every other state decodes the fill index.
  assign w_dec_idx = (r_state == IDLE) ? cpu_idx : r_idx;
  onehot_dec u_dec (.i_idx(w_dec_idx), .o_onehot(w_dec));
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_count   <= '0;
      r_base    <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      regWrite  <= 1'b0;
      decOut    <= '0;
      writeData <= '0;
      busy      <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          regWrite <= w_cpu_go;
          decOut   <= w_cpu_go ? w_dec : '0;
          if (w_cpu_go) writeData <= cpu_wdata;
          if (fill_start) begin
            r_idx    <= fill_base;
            r_len    <= w_len;
            r_base   <= fill_addr;
            r_count  <= '0;
            mem_addr <= fill_addr;
            busy     <= 1'b1;
            r_state  <= (fill_len != '0) ? REQ : DONE;
            mem_req  <= (fill_len != '0);
            fill_done <= (fill_len == '0);
          end
        end
        REQ: if (mem_ack) begin
          writeData <= mem_rdata;
          regWrite  <= 1'b1;
          decOut    <= w_dec;
          mem_req   <= 1'b0;
          r_state   <= WRITE;
        end
        WRITE: begin
          regWrite <= 1'b0;
          decOut   <= '0;
          r_idx    <= r_idx + 1'b1;
          r_count  <= w_cnt_nx;
          if (w_cnt_nx < r_len) begin
            r_state  <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= r_base + ADDR_W'({w_cnt_nx, 2'b00});
          end else begin
            r_state   <= DONE;
            fill_done <= 1'b1;
          end
        end
        DONE: begin
          fill_done <= 1'b0;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/reg_fill_ctrl.md
Name: reg_fill_ctrl

Overview:
- Write-side controller directly upstream of the 32 x 32-bit register set in the cache data path.
- Fills a run of consecutive registers from the memory side, one word per handshake, on a line-fill request.
- Also forwards single CPU writes when idle.
- Drives the register set's regWrite, decOut (one-hot) and writeData inputs; all three are registered.

Parameters:
- NUM_REGS, 32: registers in the downstream set; equals the width of decOut.
- IDX_W, 5: register index width, log2(NUM_REGS).
- DATA_W, 32: data word width.
- ADDR_W, 32: memory byte-address width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- fill_start  in  1  single-cycle fill request; sampled only in IDLE.
- fill_base  in  IDX_W  first register index of the fill.
- fill_len  in  IDX_W+1  word count; 1..32 valid.
- fill_addr  in  ADDR_W  word-aligned memory byte address of the first word.
- mem_req  out  1  memory read request; held high until acknowledged.
- mem_addr  out  ADDR_W  address of the current request.
- mem_ack  in  1  memory accepts the request; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- cpu_we  in  1  single-register write request.
- cpu_idx  in  IDX_W  target register for the CPU write.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_stall  out  1  combinational; CPU write not accepted this cycle.
- regWrite  out  1  write strobe to the register set.
- decOut  out  NUM_REGS  one-hot register select.
- writeData  out  DATA_W  data to the register set.
- busy  out  1  high whenever state is not IDLE.
- fill_done  out  1  one-cycle pulse at the end of a fill.

Behaviour:
- Reset (reset==0 at an edge): state returns to IDLE.
  - regWrite, decOut, writeData, mem_req, mem_addr, busy and fill_done all go to 0.
  - Internal idx and count registers clear to 0.
  - Reset applies mid-fill: the outstanding request is dropped and no fill_done is produced.
- States:
  - IDLE -> REQ: on fill_start with fill_len != 0.
  - IDLE -> DONE: on fill_start with fill_len == 0; no writes occur.
  - REQ -> WRITE: on mem_ack.
  - WRITE -> REQ: while count < len.
  - WRITE -> DONE: when count == len.
  - DONE -> IDLE: always, after one cycle.
- Fill start: latch fill_base into idx, min(fill_len, 32) into len, fill_addr into the address base; clear count.
- REQ:
  - mem_req=1; mem_addr = base + 4*count, modulo 2^ADDR_W.
  - mem_ack in the same cycle as entry is allowed.
  - On mem_ack: capture mem_rdata into writeData.
- WRITE (exactly one cycle):
  - regWrite=1, decOut=1<<idx, writeData holds the captured word.
  - idx increments modulo NUM_REGS (31 wraps to 0); count increments.
- Throughput: best case 2 cycles per word when mem_ack is high on the first REQ cycle.
- DONE: fill_done=1 for exactly one cycle; busy stays 1 during DONE.
- Outside WRITE and CPU-write cycles: regWrite=0 and decOut=0.
- fill_start while busy is ignored.
- CPU path:
  - cpu_stall = busy | fill_start.
  - When cpu_we=1 and cpu_stall=0, the next cycle has regWrite=1, decOut=1<<cpu_idx, writeData=cpu_wdata.
  - Latency is 1 cycle; back-to-back CPU writes achieve one per cycle.
  - A stalled CPU write is not captured; the requester holds cpu_we high.
- Simultaneous fill_start and cpu_we in IDLE: the fill wins and the CPU write is stalled.
- decOut is always zero or one-hot, never multi-hot.

Decomposition:
- Shared cache package holds:
  - state enum {IDLE, REQ, WRITE, DONE};
  - NUM_REGS / IDX_W / DATA_W constants;
  - a one-hot decode function.
- One natural sub-module: onehot_dec (IDX_W -> NUM_REGS), reusable by the read-side mux.

Test Plan:
- Reset mid-fill:
  - Stimulus: start fill base=4 len=8, hold mem_ack=1; assert reset after the 3rd WRITE.
  - Required: next cycle all outputs 0, no fill_done, registers 4..6 written only.
- Full-rate fill:
  - Stimulus: base=0, len=4, addr=0x100, mem_ack always 1, rdata=addr.
  - Required: writes decOut=0x1,0x2,0x4,0x8 with data 0x100,0x104,0x108,0x10C, one every 2 cycles, then fill_done.
- Wrap-around:
  - Stimulus: base=30, len=4.
  - Required: decOut sequence bit30, bit31, bit0, bit1.
- Zero and clamp:
  - Stimulus: len=0.
  - Required: fill_done the cycle after DONE entry, no regWrite.
  - Stimulus: len=40.
  - Required: exactly 32 writes.
- Stalled memory:
  - Stimulus: mem_ack delayed 5 cycles per word.
  - Required: mem_req held high with a stable mem_addr; no spurious regWrite.
- CPU path:
  - Stimulus: cpu_we idx=7 data=0xDEADBEEF while IDLE.
  - Required: next-cycle regWrite, decOut=0x80.
  - Stimulus: the same request during a fill.
  - Required: cpu_stall=1 and no write until the cycle after fill_done.
